// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioner: FSM encoding, default debounce
// length and the one-hot-or-zero check used by the qualifier and its bench.
package button_conditioner_pkg;

    localparam int unsigned DebCyclesDefault = 20;
    localparam int unsigned MaxButtons       = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeld    = 2'd1,
        StLockout = 2'd2
    } state_e;

    // Narrower vectors are zero-extended by the caller; true for zero or a single set bit.
    function automatic logic onehot_or_zero(input logic [MaxButtons-1:0] v);
        return (v & (v - MaxButtons'(1))) == '0;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_bit.sv
// Per-button 2-flop synchroniser followed by a stable-run counter that only moves the
// debounced level after DEB_CYCLES consecutive disagreeing samples.
module debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DebCyclesDefault,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and one-hot qualifies the raw push-buttons.
// Define BUTTON_REJECT_COUNT_EN to build the saturating multi-press reject counter.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BUTTONS  = 7,
    parameter int unsigned DEB_CYCLES = DebCyclesDefault,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] botoes_raw,
    output logic [N_BUTTONS-1:0] botoes,
    output logic                 press,
    output logic                 rejected,
    output logic [N_BUTTONS-1:0] db_debounced,
    output logic [7:0]           db_rejeitos
);

    logic [N_BUTTONS-1:0] deb;
    logic [N_BUTTONS-1:0] botoes_q, botoes_d;
    logic                 press_q, press_d;
    logic                 single, any;
    state_e               state_q, state_d;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_deb (
            .clock(clock),
            .reset(reset),
            .raw_i(botoes_raw[i]),
            .deb_o(deb[i])
        );
    end

    assign any    = |deb;
    assign single = any && onehot_or_zero(MaxButtons'(deb));

    always_comb begin
        state_d  = state_q;
        botoes_d = botoes_q;
        press_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (single) begin
                    botoes_d = deb;
                    press_d  = 1'b1;
                    state_d  = StHeld;
                end else if (any) begin
                    state_d = StLockout;
                end
            end
            StHeld: begin
                // A release plus a new press in the same cycle lands here as a mismatch.
                if (!any) begin
                    botoes_d = '0;
                    state_d  = StIdle;
                end else if (deb != botoes_q) begin
                    botoes_d = '0;
                    state_d  = StLockout;
                end
            end
            StLockout: begin
                if (!any) begin
                    state_d = StIdle;
                end
            end
            default: begin
                botoes_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            botoes_q <= '0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            botoes_q <= botoes_d;
            press_q  <= press_d;
        end
    end

`ifdef BUTTON_REJECT_COUNT_EN
    logic [7:0] rej_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rej_q <= 8'd0;
        end else if (state_d == StLockout && state_q != StLockout && rej_q != 8'hFF) begin
            rej_q <= rej_q + 8'd1;
        end
    end

    assign db_rejeitos = rej_q;
`else
    assign db_rejeitos = 8'd0;
`endif

    assign botoes       = botoes_q;
    assign press        = press_q;
    assign rejected     = (state_q == StLockout);
    assign db_debounced = deb;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEB_CYCLES=4 (7-edge latency).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int unsigned N = 7;

`ifdef BUTTON_REJECT_COUNT_EN
    localparam bit RejEn = 1'b1;
`else
    localparam bit RejEn = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] botoes_raw = '0;
    logic [N-1:0] botoes;
    logic         press;
    logic         rejected;
    logic [N-1:0] db_debounced;
    logic [7:0]   db_rejeitos;

    int n_cmp  = 0;
    int n_fail = 0;
    int rej_cnt = 0;

    button_conditioner #(
        .N_BUTTONS (N),
        .DEB_CYCLES(4),
        .CNT_W     (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .botoes_raw  (botoes_raw),
        .botoes      (botoes),
        .press       (press),
        .rejected    (rejected),
        .db_debounced(db_debounced),
        .db_rejeitos (db_rejeitos)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rej();
        return RejEn ? 8'(rej_cnt) : 8'd0;
    endfunction

    task automatic chk_all(input string tag, input logic [N-1:0] b, input logic p,
                           input logic r);
        chk({tag, ".botoes"}, 32'(botoes), 32'(b));
        chk({tag, ".press"}, 32'(press), 32'(p));
        chk({tag, ".rejected"}, 32'(rejected), 32'(r));
        chk({tag, ".onehot"}, 32'(onehot_or_zero(32'(botoes))), 32'd1);
    endtask

    initial begin
        // Reset state
        step(3);
        chk_all("rst", '0, 1'b0, 1'b0);
        chk("rst.deb", 32'(db_debounced), 32'd0);
        chk("rst.rej", 32'(db_rejeitos), 32'd0);
        reset = 1'b1;
        step(2);

        // Single press on bit 2: deb flips at edge 6, botoes/press at edge 7
        botoes_raw = 7'b0000100;
        step(5);
        chk("p2.deb_e5", 32'(db_debounced), 32'd0);
        step(1);
        chk("p2.deb_e6", 32'(db_debounced), 32'b0000100);
        chk_all("p2.e6", '0, 1'b0, 1'b0);
        step(1);
        chk_all("p2.e7", 7'b0000100, 1'b1, 1'b0);
        step(1);
        chk_all("p2.e8", 7'b0000100, 1'b0, 1'b0);
        botoes_raw = '0;
        step(6);
        chk_all("r2.e6", 7'b0000100, 1'b0, 1'b0);
        step(1);
        chk_all("r2.e7", '0, 1'b0, 1'b0);
        step(2);

        // Glitches on bit 0: 3 high / 3 low never debounce
        for (int g = 0; g < 4; g++) begin
            botoes_raw = 7'b0000001;
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("gl.deb", 32'(db_debounced), 32'd0);
                chk("gl.press", 32'(press), 32'd0);
            end
            botoes_raw = '0;
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("gl.deb", 32'(db_debounced), 32'd0);
                chk("gl.botoes", 32'(botoes), 32'd0);
            end
        end
        step(6);
        chk("gl.final", 32'(db_debounced), 32'd0);

        // Simultaneous bits 1 and 4 -> LOCKOUT
        botoes_raw = 7'b0010010;
        step(6);
        chk_all("mp.e6", '0, 1'b0, 1'b0);
        step(1);
        rej_cnt++;
        chk_all("mp.e7", '0, 1'b0, 1'b1);
        chk("mp.rej", 32'(db_rejeitos), 32'(exp_rej()));
        botoes_raw = 7'b0010000;
        step(10);
        chk_all("mp.one_left", '0, 1'b0, 1'b1);
        chk("mp.deb_one", 32'(db_debounced), 32'b0010000);
        botoes_raw = '0;
        step(6);
        chk_all("mp.rel_e6", '0, 1'b0, 1'b1);
        step(1);
        chk_all("mp.rel_e7", '0, 1'b0, 1'b0);
        chk("mp.rej_hold", 32'(db_rejeitos), 32'(exp_rej()));
        step(2);

        // Hold bit 3, then add bit 5 -> LOCKOUT, no second press
        botoes_raw = 7'b0001000;
        step(7);
        chk_all("h3.e7", 7'b0001000, 1'b1, 1'b0);
        step(3);
        botoes_raw = 7'b0101000;
        step(6);
        chk_all("h5.e6", 7'b0001000, 1'b0, 1'b0);
        step(1);
        rej_cnt++;
        chk_all("h5.e7", '0, 1'b0, 1'b1);
        chk("h5.rej", 32'(db_rejeitos), 32'(exp_rej()));
        step(1);
        chk_all("h5.e8", '0, 1'b0, 1'b1);
        botoes_raw = '0;
        step(7);
        chk_all("h5.rel", '0, 1'b0, 1'b0);
        step(2);

        // Hold bit 6, reset mid-operation, re-accept after full latency
        botoes_raw = 7'b1000000;
        step(7);
        chk_all("b6.e7", 7'b1000000, 1'b1, 1'b0);
        step(2);
        reset = 1'b0;
        #1;
        rej_cnt = 0;
        chk_all("rst6.async", '0, 1'b0, 1'b0);
        chk("rst6.deb", 32'(db_debounced), 32'd0);
        chk("rst6.rej", 32'(db_rejeitos), 32'd0);
        step(2);
        chk_all("rst6.held", '0, 1'b0, 1'b0);
        reset = 1'b1;
        step(6);
        chk_all("rst6.e6", '0, 1'b0, 1'b0);
        chk("rst6.deb_e6", 32'(db_debounced), 32'b1000000);
        step(1);
        chk_all("rst6.e7", 7'b1000000, 1'b1, 1'b0);
        step(1);
        chk_all("rst6.e8", 7'b1000000, 1'b0, 1'b0);
        botoes_raw = '0;
        step(8);

        // 260 multi-presses: reject counter saturates at 255 (or stays 0)
        for (int k = 0; k < 260; k++) begin
            botoes_raw = 7'b0000011;
            step(7);
            if (rej_cnt < 255) rej_cnt++;
            chk("sat.rejected", 32'(rejected), 32'd1);
            chk("sat.rej", 32'(db_rejeitos), 32'(exp_rej()));
            botoes_raw = '0;
            step(7);
        end
        chk("sat.final", 32'(db_rejeitos), RejEn ? 32'd255 : 32'd0);
        chk_all("sat.idle", '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
